// File: rtl/noc_pkg.sv
// noc_pkg: shared opcodes, descriptor/FSM enums and per-type body lengths for the NOC response receiver
package noc_pkg;
  localparam logic [2:0] OP_RD_RSP = 3'b011;
  localparam logic [2:0] OP_WR_RSP = 3'b100;
  localparam logic [2:0] OP_MSG = 3'b101;
  localparam logic [8:0] HDR_BODY_LEN = 9'd3;
  localparam logic [8:0] WR_BODY_LEN = 9'd4;
  localparam logic [8:0] MSG_BODY_LEN = 9'd5;
  typedef enum logic [1:0] {RSP_RD = 2'd0, RSP_WR = 2'd1, RSP_MSG = 2'd2} rsp_type_e;
  typedef enum logic [2:0] {S_IDLE, S_DEST, S_SRC, S_LEN, S_DATA, S_STAT, S_RSVD} state_e;
  function automatic logic [8:0] body_len(rsp_type_e t, logic [7:0] len);
    return t == RSP_RD ? HDR_BODY_LEN + {1'b0, len} : t == RSP_WR ? WR_BODY_LEN : MSG_BODY_LEN;
  endfunction
endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: {last,data} byte FIFO with a registered output stage counted in the DEPTH capacity
module rx_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       rd_ready,
  output logic       full,
  output logic       empty,
  output logic [8:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [8:0] dout_q, dout_d;
  logic valid_q, valid_d;
  logic [8:0] mem [DEPTH];
  logic pop, wr_ok, load, mem_empty, bypass, mem_wr, rd_mem;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    pop = valid_q && rd_ready;
    wr_ok = push && !full;
    load = !valid_q || pop;
    mem_empty = cnt_q == (AW+1)'(valid_q);
    // an empty FIFO forwards straight into the output stage so data shows one cycle after push
    bypass = load && mem_empty;
    mem_wr = wr_ok && !bypass;
    rd_mem = load && !mem_empty;
    valid_d = load ? (!mem_empty || wr_ok) : valid_q;
    dout_d = rd_mem ? mem[rptr_q] : (bypass && wr_ok) ? din : dout_q;
    rptr_d = rptr_q + AW'(rd_mem);
    wptr_d = wptr_q + AW'(mem_wr);
    cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    dout = dout_q;
  end
  always_ff @(posedge clk) if (mem_wr) mem[wptr_q] <= din;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/noc_rsp_rx.sv
// noc_rsp_rx: parses the NOC response byte stream into a held descriptor and a read-data byte stream
module noc_rsp_rx
  import noc_pkg::*;
#(
  parameter int DATA_DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noc_from_dev_ctl,
  input  logic [7:0] noc_from_dev_data,
  output logic       rsp_valid,
  output logic [1:0] rsp_type,
  output logic [7:0] rsp_dest,
  output logic [7:0] rsp_src,
  output logic [7:0] rsp_len,
  output logic [7:0] rsp_status,
  input  logic       rsp_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_last,
  input  logic       rd_ready,
  output logic       err_proto,
  output logic [7:0] drop_cnt,
  output logic       ovf
);
  state_e state_q, state_d;
  rsp_type_e ptype_q, ptype_d, op_type, rsp_type_q, rsp_type_d;
  logic [7:0] dest_q, dest_d, src_q, src_d, len_q, len_d, stat_q, stat_d, len_cur;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] rsp_dest_q, rsp_dest_d, rsp_src_q, rsp_src_d, rsp_len_q, rsp_len_d, rsp_status_q, rsp_status_d;
  logic [7:0] drop_q, drop_d;
  logic rsp_valid_q, rsp_valid_d, err_q, err_d, ovf_q, ovf_d;
  logic hdr, body, op_ok, active, done, acc, load, push, fifo_full, fifo_empty;
  logic [2:0] op;
  logic [8:0] fifo_dout;
  always_comb begin
    hdr = noc_from_dev_ctl && noc_from_dev_data != 8'd0;
    body = !noc_from_dev_ctl;
    op = noc_from_dev_data[2:0];
    op_ok = op == OP_RD_RSP || op == OP_WR_RSP || op == OP_MSG;
    op_type = op == OP_RD_RSP ? RSP_RD : op == OP_WR_RSP ? RSP_WR : RSP_MSG;
    active = body && state_q != S_IDLE;
    len_cur = state_q == S_LEN ? noc_from_dev_data : len_q;
    done = active && cnt_q + 9'd1 == body_len(ptype_q, len_cur);
    err_d = (hdr && (state_q != S_IDLE || !op_ok)) || (body && state_q == S_IDLE);
    state_d = state_q;
    ptype_d = ptype_q;
    cnt_d = cnt_q;
    dest_d = dest_q;
    src_d = src_q;
    len_d = len_q;
    stat_d = stat_q;
    // a header always restarts parsing, aborting any packet in flight
    if (hdr) begin
      state_d = op_ok ? S_DEST : S_IDLE;
      ptype_d = op_ok ? op_type : ptype_q;
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 9'd1;
      dest_d = state_q == S_DEST ? noc_from_dev_data : dest_q;
      src_d = state_q == S_SRC ? noc_from_dev_data : src_q;
      len_d = state_q == S_LEN ? noc_from_dev_data : len_q;
      stat_d = state_q == S_STAT ? noc_from_dev_data : stat_q;
      state_d = done ? S_IDLE :
                state_q == S_DEST ? S_SRC :
                state_q == S_SRC ? S_LEN :
                state_q == S_LEN ? (ptype_q == RSP_RD ? S_DATA : S_STAT) :
                state_q == S_STAT ? S_RSVD : state_q;
    end
    push = active && state_q == S_DATA;
    acc = rsp_valid_q && rsp_ready;
    load = done && (!rsp_valid_q || acc);
    rsp_valid_d = load || (rsp_valid_q && !acc);
    rsp_type_d = load ? ptype_q : rsp_type_q;
    rsp_dest_d = load ? dest_q : rsp_dest_q;
    rsp_src_d = load ? src_q : rsp_src_q;
    rsp_len_d = load ? len_cur : rsp_len_q;
    rsp_status_d = !load ? rsp_status_q : ptype_q == RSP_RD ? 8'd0 :
                   state_q == S_STAT ? noc_from_dev_data : stat_q;
    drop_d = (done && !load && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    ovf_d = ovf_q || (push && fifo_full);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptype_q <= RSP_RD;
      cnt_q <= '0;
      dest_q <= '0;
      src_q <= '0;
      len_q <= '0;
      stat_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_type_q <= RSP_RD;
      rsp_dest_q <= '0;
      rsp_src_q <= '0;
      rsp_len_q <= '0;
      rsp_status_q <= '0;
      err_q <= 1'b0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptype_q <= ptype_d;
      cnt_q <= cnt_d;
      dest_q <= dest_d;
      src_q <= src_d;
      len_q <= len_d;
      stat_q <= stat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_type_q <= rsp_type_d;
      rsp_dest_q <= rsp_dest_d;
      rsp_src_q <= rsp_src_d;
      rsp_len_q <= rsp_len_d;
      rsp_status_q <= rsp_status_d;
      err_q <= err_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  rx_byte_fifo #(.DEPTH(DATA_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({done, noc_from_dev_data}),
    .rd_ready(rd_ready),
    .full(fifo_full),
    .empty(fifo_empty),
    .dout(fifo_dout)
  );
  assign rsp_valid = rsp_valid_q;
  assign rsp_type = rsp_type_q;
  assign rsp_dest = rsp_dest_q;
  assign rsp_src = rsp_src_q;
  assign rsp_len = rsp_len_q;
  assign rsp_status = rsp_status_q;
  assign rd_valid = !fifo_empty;
  assign rd_data = fifo_dout[7:0];
  assign rd_last = fifo_dout[8];
  assign err_proto = err_q;
  assign drop_cnt = drop_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_noc_rsp_rx.sv
// tb_noc_rsp_rx: packet-level reference model with per-cycle compare plus directed literal checks
module tb_noc_rsp_rx;
  localparam int DEPTH = 64;
  logic clk = 0, reset = 0, ctl = 1, rsp_ready = 0, rd_ready = 0;
  logic [7:0] din = 0;
  logic rsp_valid, rd_valid, rd_last, err_proto, ovf;
  logic [1:0] rsp_type;
  logic [7:0] rsp_dest, rsp_src, rsp_len, rsp_status, rd_data, drop_cnt;
  int checks = 0, errors = 0;
  bit go = 0, rnd = 0, err_seen = 0;
  bit m_in, m_rv, m_ovf, m_err;
  int m_type;
  byte unsigned cur[$];
  logic [8:0] fq[$];
  logic [1:0] m_rt;
  logic [7:0] m_rd, m_rs, m_rl, m_rst, m_drop;

  always #5 clk = ~clk;

  noc_rsp_rx #(.DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .noc_from_dev_ctl(ctl), .noc_from_dev_data(din),
    .rsp_valid(rsp_valid), .rsp_type(rsp_type), .rsp_dest(rsp_dest), .rsp_src(rsp_src),
    .rsp_len(rsp_len), .rsp_status(rsp_status), .rsp_ready(rsp_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .err_proto(err_proto), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // model: a packet is the list of body bytes after its header; it completes when the list reaches its length
  always @(posedge clk or posedge reset) begin : model
    int n, need;
    bit e, done, pv, acc, full;
    if (reset) begin
      m_in = 0; cur.delete(); fq.delete(); m_rv = 0; m_rt = 0; m_rd = 0; m_rs = 0;
      m_rl = 0; m_rst = 0; m_drop = 0; m_ovf = 0; m_err = 0; m_type = 0;
    end else begin
      e = 0; done = 0; pv = 0; acc = m_rv && rsp_ready;
      if (ctl && din != 0) begin
        if (m_in) e = 1;
        m_in = 0; cur.delete();
        if (din[2:0] inside {3'd3, 3'd4, 3'd5}) begin m_in = 1; m_type = int'(din[2:0]); end
        else e = 1;
      end else if (!ctl) begin
        if (!m_in) e = 1;
        else begin
          cur.push_back(din);
          n = cur.size();
          need = m_type == 3 ? (n >= 3 ? 3 + int'(cur[2]) : 1000) : m_type == 4 ? 4 : 5;
          done = n == need;
          pv = m_type == 3 && n > 3;
        end
      end
      full = fq.size() == DEPTH;
      if (fq.size() > 0 && rd_ready) void'(fq.pop_front());
      if (pv) begin
        if (full) m_ovf = 1;
        else fq.push_back({done, din});
      end
      if (done) begin
        if (!m_rv || acc) begin
          m_rv = 1; m_rt = m_type == 3 ? 2'd0 : m_type == 4 ? 2'd1 : 2'd2;
          m_rd = cur[0]; m_rs = cur[1]; m_rl = cur[2]; m_rst = m_type == 3 ? 8'd0 : cur[3];
        end else if (m_drop != 8'd255) m_drop++;
        m_in = 0; cur.delete();
      end else if (acc) m_rv = 0;
      m_err = e;
    end
  end

  always @(negedge clk) begin
    if (err_proto) err_seen = 1;
    if (go && !reset) begin
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rsp_type", rsp_type, m_rt);
        chk("rsp_dest", rsp_dest, m_rd);
        chk("rsp_src", rsp_src, m_rs);
        chk("rsp_len", rsp_len, m_rl);
        chk("rsp_status", rsp_status, m_rst);
      end
      chk("rd_valid", rd_valid, fq.size() > 0);
      if (fq.size() > 0) begin
        chk("rd_data", rd_data, fq[0][7:0]);
        chk("rd_last", rd_last, fq[0][8]);
      end
      chk("err_proto", err_proto, m_err);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic put(input logic c, input logic [7:0] d);
    ctl = c; din = d;
    if (rnd) begin
      rsp_ready = $urandom_range(0, 1) == 1;
      rd_ready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1, 0);
  endtask

  task automatic pkt(input byte unsigned b[$]);
    put(1, b[0]);
    for (int i = 1; i < b.size(); i++) put(0, b[i]);
  endtask

  task automatic clr;
    rsp_ready = 1; put(1, 0); rsp_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [8:0] lastb;
    logic [7:0] hb, op;
    int nb, L;
    #1 reset = 1;
    repeat (3) @(negedge clk);
    #2 reset = 0; go = 1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rd_valid", rd_valid, 0);
    chk("rst_drop", drop_cnt, 0); chk("rst_ovf", ovf, 0); chk("rst_err", err_proto, 0);
    // RD_RSP with four data bytes
    pkt('{8'h03, 8'h10, 8'h40, 8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3});
    chk("rd_desc_valid", rsp_valid, 1); chk("rd_desc_type", rsp_type, 0);
    chk("rd_desc_dest", rsp_dest, 8'h10); chk("rd_desc_src", rsp_src, 8'h40);
    chk("rd_desc_len", rsp_len, 4); chk("rd_desc_status", rsp_status, 0);
    idle(1);
    rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("rd_byte", rd_data, 8'hA0 + i);
      chk("rd_byte_last", rd_last, i == 3);
      put(1, 0);
    end
    rd_ready = 0;
    chk("rd_drained", rd_valid, 0);
    clr();
    chk("rsp_cleared", rsp_valid, 0);
    // WR_RSP with idle gaps
    err_seen = 0;
    put(1, 8'h04); put(1, 0); put(0, 8'h11); put(1, 0); put(1, 0);
    put(0, 8'h41); put(1, 0); put(0, 8'h08); put(1, 0); put(0, 8'h00);
    chk("wr_type", rsp_type, 1); chk("wr_len", rsp_len, 8); chk("wr_status", rsp_status, 0);
    chk("wr_dest", rsp_dest, 8'h11);
    idle(1);
    chk("wr_no_err", err_seen, 0);
    clr();
    // MSG drop / accept-on-completion
    pkt('{8'h05, 8'h12, 8'h42, 8'h03, 8'h55, 8'h99}); idle(1);
    chk("msg1_dest", rsp_dest, 8'h12); chk("msg1_status", rsp_status, 8'h55); chk("msg1_drop", drop_cnt, 0);
    pkt('{8'h05, 8'h13, 8'h43, 8'h02, 8'h66, 8'h77}); idle(1);
    chk("msg2_held_dest", rsp_dest, 8'h12); chk("msg2_drop", drop_cnt, 1);
    put(1, 8'h05); put(0, 8'h14); put(0, 8'h44); put(0, 8'h01); put(0, 8'h88);
    rsp_ready = 1; put(0, 8'hEE); rsp_ready = 0;
    chk("msg3_valid", rsp_valid, 1); chk("msg3_dest", rsp_dest, 8'h14);
    chk("msg3_type", rsp_type, 2); chk("msg3_drop", drop_cnt, 1);
    idle(1); clr();
    // overflow: 70 data bytes into a 64-byte FIFO
    put(1, 8'h03); put(0, 8'h22); put(0, 8'h52); put(0, 8'd70);
    for (int i = 0; i < 70; i++) put(0, 8'(i));
    idle(1);
    chk("ovf_set", ovf, 1); chk("ovf_len", rsp_len, 70); chk("ovf_first", rd_data, 0);
    rd_ready = 1; n = 0; lastb = 0;
    for (int k = 0; k < 200 && rd_valid; k++) begin
      lastb = {rd_last, rd_data}; n++; put(1, 0);
    end
    rd_ready = 0;
    chk("ovf_held_count", n, 64); chk("ovf_last_held", lastb, 9'd63);
    clr();
    // abort by header mid-packet, bad opcode, stray body byte
    put(1, 8'h03); put(0, 8'h20); put(0, 8'h50); put(1, 8'h04);
    chk("abort_err", err_proto, 1);
    put(0, 8'h21);
    chk("abort_err_one", err_proto, 0);
    put(0, 8'h51); put(0, 8'h00); put(0, 8'h00);
    chk("abort_wr_type", rsp_type, 1); chk("abort_wr_dest", rsp_dest, 8'h21);
    clr();
    put(1, 8'h07);
    chk("badop_err", err_proto, 1);
    put(1, 0);
    chk("badop_err_one", err_proto, 0); chk("badop_no_desc", rsp_valid, 0);
    put(0, 8'h33);
    chk("stray_err", err_proto, 1);
    idle(2);
    // reset during DATA
    pkt('{8'h03, 8'h30, 8'h60, 8'h05, 8'hB0, 8'hB1});
    put(1, 0);
    chk("pre_rst_rd_valid", rd_valid, 1);
    #2 reset = 1; #1;
    chk("rst2_rsp_valid", rsp_valid, 0); chk("rst2_rsp_type", rsp_type, 0);
    chk("rst2_rsp_dest", rsp_dest, 0); chk("rst2_rsp_src", rsp_src, 0);
    chk("rst2_rsp_len", rsp_len, 0); chk("rst2_rsp_status", rsp_status, 0);
    chk("rst2_rd_valid", rd_valid, 0); chk("rst2_rd_data", rd_data, 0); chk("rst2_rd_last", rd_last, 0);
    chk("rst2_err", err_proto, 0); chk("rst2_drop", drop_cnt, 0); chk("rst2_ovf", ovf, 0);
    @(negedge clk); #2 reset = 0;
    @(negedge clk);
    pkt('{8'h03, 8'h31, 8'h61, 8'h02, 8'hC0, 8'hC1});
    chk("post_rst_dest", rsp_dest, 8'h31); chk("post_rst_len", rsp_len, 2);
    chk("post_rst_data", rd_data, 8'hC0); chk("post_rst_last", rd_last, 0);
    idle(1); clr();
    rd_ready = 1; idle(3); rd_ready = 0;
    // randomized traffic against the model
    rnd = 1;
    for (int p = 0; p < 80; p++) begin
      op = 8'($urandom_range(0, 9));
      op = op < 3 ? 8'd3 : op < 6 ? 8'd4 : op < 8 ? 8'd5 : 8'($urandom_range(0, 7));
      hb = {5'($urandom), op[2:0]};
      if (hb == 0) hb = 8'h80;
      L = $urandom_range(0, 20);
      nb = op == 3 ? 3 + L : op == 4 ? 4 : op == 5 ? 5 : $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) nb = $urandom_range(0, nb);
      if ($urandom_range(0, 9) == 0) put(0, 8'($urandom));
      put(1, hb);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) put(1, 0);
        put(0, i == 2 ? 8'(L) : 8'($urandom));
      end
    end
    rnd = 0; rsp_ready = 1; rd_ready = 1;
    idle(80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_rsp_rx.md
NOC_RSP_RX -- requirements
Module: noc_rsp_rx

Interface
REQ-001 The block SHALL have parameter DATA_DEPTH, default 64, power of two >= 4, giving the read-data FIFO depth in bytes.
REQ-002 The block SHALL have port clk  in  1  the single clock; every register is on its rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port noc_from_dev_ctl  in  1  NOC response stream control: 1 = header/idle byte, 0 = body byte.
REQ-005 The block SHALL have port noc_from_dev_data  in  8  NOC response stream byte.
REQ-006 The block SHALL have output ports rsp_valid (1), rsp_type (2), rsp_dest (8), rsp_src (8), rsp_len (8) and rsp_status (8), which form the response descriptor.
REQ-007 The block SHALL have port rsp_ready  in  1  descriptor accept from the host.
REQ-008 The block SHALL have output ports rd_valid (1), rd_data (8) and rd_last (1), which form the read-data stream.
REQ-009 The block SHALL have port rd_ready  in  1  read-data accept from the host.
REQ-010 The block SHALL have output port err_proto (1), a one-cycle pulse on any protocol violation.
REQ-011 The block SHALL have output ports drop_cnt (8) and ovf (1), where drop_cnt counts dropped descriptors and ovf is a sticky read-data overflow flag.

Function
REQ-012 A header byte SHALL be a byte with ctl=1 and data!=0; ctl=1 with data=0 SHALL be idle; the opcode SHALL be data[2:0].
REQ-013 Opcodes SHALL be 011 RD_RSP, 100 WR_RSP and 101 MSG; any other header SHALL pulse err_proto and leave the FSM in IDLE.
REQ-014 RD_RSP body bytes SHALL be dest, src, len L, then L data bytes.
REQ-015 WR_RSP body bytes SHALL be dest, src, len, status.
REQ-016 MSG body bytes SHALL be dest, src, len, status, then one reserved byte that is discarded.
REQ-017 The FSM SHALL have states IDLE, DEST, SRC, LEN, DATA, STAT, RSVD.
REQ-018 The FSM SHALL transition IDLE->DEST on a valid header and DEST->SRC->LEN on successive body bytes.
REQ-019 From LEN, RD_RSP SHALL go to DATA, or to IDLE if L=0; WR_RSP and MSG SHALL go to STAT.
REQ-020 From DATA the FSM SHALL go to IDLE after L bytes.
REQ-021 From STAT, WR_RSP SHALL go to IDLE and MSG SHALL go to RSVD; RSVD SHALL go to IDLE.
REQ-022 The FSM SHALL ignore idle bytes in every state, so gaps inside a packet are permitted.
REQ-023 Each RD_RSP data byte SHALL be pushed to the FIFO in the cycle it is sampled, with rd_last=1 on byte L.
REQ-024 FIFO output SHALL be registered: rd_valid SHALL rise one cycle after a push into an empty FIFO.
REQ-025 A read-data byte arriving with the FIFO full SHALL be dropped and SHALL set ovf, which stays set until reset.
REQ-026 The FIFO SHALL transfer a byte when rd_valid&rd_ready; pointers SHALL wrap modulo DATA_DEPTH; simultaneous push and pop when full SHALL NOT be permitted (the push is dropped as in REQ-025).
REQ-027 The descriptor SHALL be loaded and rsp_valid SHALL assert in the cycle after the final body byte is sampled (for L=0, the cycle after len).
REQ-028 rsp_type SHALL be 0 RD, 1 WR, 2 MSG; rsp_status SHALL be 0 for RD_RSP.
REQ-029 rsp_valid SHALL hold, with the descriptor stable, until rsp_valid&rsp_ready.
REQ-030 A completing packet while the descriptor is pending and not accepted that cycle SHALL be discarded and SHALL increment drop_cnt, saturating at 255.
REQ-031 Acceptance and a new completion in the same cycle SHALL load the new descriptor with no drop.
REQ-032 A header arriving in any non-IDLE state SHALL pulse err_proto and abort the current packet with no descriptor; already-pushed data SHALL stay in the FIFO, with no rd_last inserted.
REQ-033 After an abort per REQ-032, the new header SHALL be decoded in that cycle.
REQ-034 A body byte (ctl=0) in IDLE SHALL pulse err_proto and be ignored.

Reset
REQ-035 On reset the FSM SHALL enter IDLE and the FIFO SHALL be emptied.
REQ-036 On reset all outputs SHALL be 0 (rsp_*, rd_*, err_proto, drop_cnt, ovf).
REQ-037 Reset asserted mid-packet SHALL discard the packet; the first header after deassertion SHALL be decoded normally.

Structure
REQ-038 Opcode constants, the rsp_type enum, the FSM state enum and per-type body lengths SHALL reside in shared package noc_pkg.
REQ-039 The read-data FIFO SHALL be sub-module rx_byte_fifo (9-bit entry {last,data}, parameter DEPTH, full/empty outputs).

Verification
REQ-040 Bench SHALL cover: RD_RSP 0x03,0x10,0x40,0x04,A0..A3 -> rsp_valid with type0/dest 0x10/src 0x40/len 4; rd_data A0..A3 with rd_last on A3.
REQ-041 Bench SHALL cover: WR_RSP 0x04,0x11,0x41,0x08,0x00 with idle gaps between bytes -> type1/len 8/status 0, err_proto never pulses.
REQ-042 Bench SHALL cover: two MSG packets with rsp_ready=0 -> first descriptor held, drop_cnt=1; rsp_ready=1 on the second's completion cycle -> second loaded, drop_cnt unchanged.
REQ-043 Bench SHALL cover: RD_RSP with L=70 at DATA_DEPTH=64 and rd_ready=0 -> 64 bytes held, ovf=1.
REQ-044 Bench SHALL cover: header 0x04 after the src byte of a RD_RSP -> err_proto one cycle, no RD descriptor, WR_RSP decoded; header 0x07 -> err_proto, FSM stays IDLE.
REQ-045 Bench SHALL cover: reset during DATA -> all outputs 0; the next RD_RSP is decoded correctly.
